// File: rtl/exe_stage_pipe_param_if.sv
// EXE->MEM pipeline bundle: upstream instruction fields in, last-stage fields,
// status and hazard-unit views out.
interface exe_stage_pipe_param_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int STATUS_W   = 4,
  parameter int DEPTH      = 1
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                        freeze;
  logic                        flush;
  logic                        in_valid;
  logic                        wb_en_in;
  logic                        mem_r_en_in;
  logic                        mem_w_en_in;
  logic                        s_in;
  logic [STATUS_W-1:0]         status_in;
  logic [DATA_W-1:0]           alu_res_in;
  logic [DATA_W-1:0]           val_r_m_in;
  logic [REG_ADDR_W-1:0]       dest_in;

  logic                        out_valid;
  logic                        wb_en_out;
  logic                        mem_r_en_out;
  logic                        mem_w_en_out;
  logic [DATA_W-1:0]           alu_res_out;
  logic [DATA_W-1:0]           val_r_m_out;
  logic [REG_ADDR_W-1:0]       dest_out;
  logic [STATUS_W-1:0]         status_reg;
  logic [DEPTH*REG_ADDR_W-1:0] inflight_dest;
  logic [DEPTH-1:0]            inflight_wb;
  logic [OCC_W-1:0]            occupancy;

  modport master (
    output freeze, flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, s_in,
           status_in, alu_res_in, val_r_m_in, dest_in,
    input  out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out,
           val_r_m_out, dest_out, status_reg, inflight_dest, inflight_wb, occupancy
  );

  modport slave (
    input  freeze, flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, s_in,
           status_in, alu_res_in, val_r_m_in, dest_in,
    output out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, alu_res_out,
           val_r_m_out, dest_out, status_reg, inflight_dest, inflight_wb, occupancy
  );
endinterface

// File: rtl/exe_stage_pipe_param.sv
// Parametrised EXE->MEM pipeline register (DEPTH stages) with stall, flush,
// per-stage valid, hazard-unit destination views and the NZCV status register.
module exe_stage_pipe_param #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int STATUS_W   = 4,
  parameter int DEPTH      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  exe_stage_pipe_param_if.slave   bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("exe_stage_pipe_param: DEPTH must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic                  vld;
    logic                  wb;
    logic                  mr;
    logic                  mw;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rm;
    logic [REG_ADDR_W-1:0] dest;
  } stage_t;

  stage_t                      r_stg [DEPTH];
  stage_t                      w_in;
  logic [STATUS_W-1:0]         r_status;
  logic                        w_status_we;
  logic [OCC_W-1:0]            w_occ;
  logic [DEPTH*REG_ADDR_W-1:0] w_idest;
  logic [DEPTH-1:0]            w_iwb;

  // A non-valid instruction enters as an all-zero bubble
  always_comb begin
    w_in = '0;
    if (bus.in_valid) begin
      w_in.vld  = 1'b1;
      w_in.wb   = bus.wb_en_in;
      w_in.mr   = bus.mem_r_en_in;
      w_in.mw   = bus.mem_w_en_in;
      w_in.alu  = bus.alu_res_in;
      w_in.rm   = bus.val_r_m_in;
      w_in.dest = bus.dest_in;
    end
  end

  assign w_status_we = bus.s_in & bus.in_valid & ~bus.flush & ~bus.freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_stg[k] <= '0;
      r_status <= '0;
    end else begin
      // Flush beats freeze at stage 0 so a stalled pipe can still kill the incoming op
      if (bus.flush)        r_stg[0] <= '0;
      else if (!bus.freeze) r_stg[0] <= w_in;
      if (!bus.freeze) begin
        for (int k = 1; k < DEPTH; k++) r_stg[k] <= r_stg[k-1];
      end
      if (w_status_we) r_status <= bus.status_in;
    end
  end

  always_comb begin
    w_occ   = '0;
    w_idest = '0;
    w_iwb   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idest[k*REG_ADDR_W +: REG_ADDR_W] = r_stg[k].dest;
      w_iwb[k] = r_stg[k].vld & r_stg[k].wb;
      w_occ    = w_occ + OCC_W'(r_stg[k].vld);
    end
  end

  assign bus.out_valid     = r_stg[DEPTH-1].vld;
  assign bus.wb_en_out     = r_stg[DEPTH-1].vld & r_stg[DEPTH-1].wb;
  assign bus.mem_r_en_out  = r_stg[DEPTH-1].vld & r_stg[DEPTH-1].mr;
  assign bus.mem_w_en_out  = r_stg[DEPTH-1].vld & r_stg[DEPTH-1].mw;
  assign bus.alu_res_out   = r_stg[DEPTH-1].alu;
  assign bus.val_r_m_out   = r_stg[DEPTH-1].rm;
  assign bus.dest_out      = r_stg[DEPTH-1].dest;
  assign bus.status_reg    = r_status;
  assign bus.inflight_dest = w_idest;
  assign bus.inflight_wb   = w_iwb;
  assign bus.occupancy     = w_occ;
endmodule

// File: tb/tb_exe_stage_pipe_param.sv
// Bench for exe_stage_pipe_param: four instances (DEPTH 1..4) share one stimulus
// stream; a per-depth queue scoreboard predicts every output each cycle.
module tb_exe_stage_pipe_param;
  logic        clk, rst;
  logic        t_freeze, t_flush, t_in_valid, t_wb, t_mr, t_mw, t_s;
  logic [3:0]  t_status, t_dest;
  logic [31:0] t_alu, t_rm;

  logic        a_vld [1:4], a_wb [1:4], a_mr [1:4], a_mw [1:4];
  logic [31:0] a_alu [1:4], a_rm [1:4];
  logic [3:0]  a_dest [1:4], a_status [1:4], a_iwb [1:4];
  logic [15:0] a_idest [1:4];
  logic [2:0]  a_occ [1:4];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic vld, wb, mr, mw;
    logic [31:0] alu, rm;
    logic [3:0]  dest;
  } rec_t;

  typedef struct packed {
    logic vld, wb, mr, mw;
    logic [31:0] alu, rm;
    logic [3:0]  dest, status;
    logic [15:0] idest;
    logic [3:0]  iwb;
    logic [2:0]  occ;
  } out_t;

  rec_t       sbq [1:4][$];
  logic [3:0] exp_status;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = g + 1;
    exe_stage_pipe_param_if #(.DATA_W(32), .REG_ADDR_W(4), .STATUS_W(4), .DEPTH(D)) bus ();
    assign bus.freeze      = t_freeze;
    assign bus.flush       = t_flush;
    assign bus.in_valid    = t_in_valid;
    assign bus.wb_en_in    = t_wb;
    assign bus.mem_r_en_in = t_mr;
    assign bus.mem_w_en_in = t_mw;
    assign bus.s_in        = t_s;
    assign bus.status_in   = t_status;
    assign bus.alu_res_in  = t_alu;
    assign bus.val_r_m_in  = t_rm;
    assign bus.dest_in     = t_dest;
    exe_stage_pipe_param #(.DATA_W(32), .REG_ADDR_W(4), .STATUS_W(4), .DEPTH(D)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign a_vld[D]    = bus.out_valid;
    assign a_wb[D]     = bus.wb_en_out;
    assign a_mr[D]     = bus.mem_r_en_out;
    assign a_mw[D]     = bus.mem_w_en_out;
    assign a_alu[D]    = bus.alu_res_out;
    assign a_rm[D]     = bus.val_r_m_out;
    assign a_dest[D]   = bus.dest_out;
    assign a_status[D] = bus.status_reg;
    assign a_idest[D]  = 16'(bus.inflight_dest);
    assign a_iwb[D]    = 4'(bus.inflight_wb);
    assign a_occ[D]    = 3'(bus.occupancy);
  end

  task automatic sb_reset();
    for (int d = 1; d <= 4; d++) begin
      sbq[d].delete();
      repeat (d) sbq[d].push_back('0);
    end
    exp_status = 4'h0;
  endtask

  // Queue holds DEPTH entries: front is the last stage, back is stage 0
  task automatic sb_update();
    rec_t n;
    if (rst) begin
      sb_reset();
    end else begin
      n = '0;
      if (t_in_valid && !t_flush) begin
        n.vld = 1'b1; n.wb = t_wb; n.mr = t_mr; n.mw = t_mw;
        n.alu = t_alu; n.rm = t_rm; n.dest = t_dest;
      end
      for (int d = 1; d <= 4; d++) begin
        if (!t_freeze) begin
          sbq[d].push_back(n);
          void'(sbq[d].pop_front());
        end else if (t_flush) begin
          sbq[d][d-1] = '0;
        end
      end
      if (t_s && t_in_valid && !t_flush && !t_freeze) exp_status = t_status;
    end
  endtask

  function automatic out_t exp_out(int d);
    out_t e;
    rec_t s;
    e = '0;
    s = sbq[d][0];
    e.vld = s.vld; e.wb = s.wb; e.mr = s.mr; e.mw = s.mw;
    e.alu = s.alu; e.rm = s.rm; e.dest = s.dest;
    e.status = exp_status;
    for (int k = 0; k < d; k++) begin
      s = sbq[d][d-1-k];
      e.idest[k*4 +: 4] = s.dest;
      e.iwb[k] = s.vld & s.wb;
      e.occ = e.occ + 3'(s.vld);
    end
    return e;
  endfunction

  function automatic out_t act_out(int d);
    out_t a;
    a.vld = a_vld[d]; a.wb = a_wb[d]; a.mr = a_mr[d]; a.mw = a_mw[d];
    a.alu = a_alu[d]; a.rm = a_rm[d]; a.dest = a_dest[d];
    a.status = a_status[d]; a.idest = a_idest[d]; a.iwb = a_iwb[d]; a.occ = a_occ[d];
    return a;
  endfunction

  task automatic cycle();
    @(posedge clk);
    sb_update();
    #1;
  endtask

  task automatic idle();
    t_freeze = 0; t_flush = 0; t_in_valid = 0; t_wb = 0; t_mr = 0; t_mw = 0; t_s = 0;
    t_status = 4'h0; t_dest = 4'h0; t_alu = 32'h0; t_rm = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    for (int d = 1; d <= 4; d++) begin
      checks++;
      if (act_out(d) !== exp_out(d) || act_out(d) !== out_t'(0)) begin
        errors++;
        $display("FAIL reset d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    t_in_valid = 1; t_wb = 1; t_alu = 32'h0000_00A5; t_dest = 4'd3;
    cycle();
    checks++;
    if ({a_vld[1], a_wb[1], a_alu[1], a_dest[1]} !== {1'b1, 1'b1, 32'hA5, 4'd3}) begin
      errors++;
      $display("FAIL single_d1 got=%b%b %h %h exp=11 000000a5 3", a_vld[1], a_wb[1], a_alu[1], a_dest[1]);
    end
    for (int d = 1; d <= 4; d++) begin
      checks++;
      if (act_out(d) !== exp_out(d)) begin
        errors++;
        $display("FAIL single d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
      end
    end
    idle();
    repeat (4) begin
      cycle();
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++;
          $display("FAIL single_drain d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
        end
      end
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 3) begin
        t_in_valid = 1; t_wb = 1; t_alu = 32'(i); t_rm = 32'(i * 16); t_dest = 4'(i);
      end else begin
        idle();
      end
      cycle();
      if (i == 3) begin
        checks++;
        if ({a_alu[3], a_occ[3], a_iwb[3]} !== {32'd1, 3'd3, 4'b0111}) begin
          errors++;
          $display("FAIL stream_full_d3 got=%h occ=%0d iwb=%b exp=1 occ=3 iwb=0111", a_alu[3], a_occ[3], a_iwb[3]);
        end
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (a_alu[3] !== 32'(i - 2) || a_vld[3] !== 1'b1) begin
          errors++;
          $display("FAIL stream_order_d3 got=%h vld=%b exp=%h vld=1", a_alu[3], a_vld[3], 32'(i - 2));
        end
      end
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++;
          $display("FAIL stream d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
        end
      end
    end
  endtask

  task automatic test_freeze_flush();
    logic [31:0] exp_alu [4];
    logic        exp_vld [4];
    exp_alu = '{32'hAAAA, 32'hAAAA, 32'hAAAA, 32'h0};
    exp_vld = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin t_in_valid = 1; t_wb = 1; t_alu = 32'hAAAA; t_dest = 4'd5; end
        1: begin t_in_valid = 1; t_wb = 1; t_alu = 32'hBBBB; t_dest = 4'd6; end
        2: begin t_in_valid = 1; t_alu = 32'hCCCC; t_freeze = 1; t_flush = 1; end
        3: begin t_in_valid = 1; t_alu = 32'hDDDD; t_freeze = 1; end
        default: ;
      endcase
      cycle();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (a_alu[2] !== exp_alu[i-1] || a_vld[2] !== exp_vld[i-1]) begin
          errors++;
          $display("FAIL freeze_d2 step=%0d got=%h vld=%b exp=%h vld=%b", i, a_alu[2], a_vld[2], exp_alu[i-1], exp_vld[i-1]);
        end
      end
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++;
          $display("FAIL freeze d=%0d step=%0d got=%h exp=%h", d, i, act_out(d), exp_out(d));
        end
      end
    end
  endtask

  task automatic test_status();
    logic [3:0] want [5];
    want = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1001};
    for (int i = 0; i < 5; i++) begin
      idle();
      t_s = 1; t_in_valid = (i != 3); t_status = (i == 0) ? 4'b0110 : 4'b1001;
      t_flush = (i == 1); t_freeze = (i == 2);
      cycle();
      checks++;
      if (a_status[1] !== want[i] || a_status[4] !== want[i]) begin
        errors++;
        $display("FAIL status step=%0d got=%b/%b exp=%b", i, a_status[1], a_status[4], want[i]);
      end
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++;
          $display("FAIL status_sb d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
        end
      end
    end
  endtask

  task automatic test_invalid();
    idle();
    t_in_valid = 0; t_wb = 1; t_mw = 1; t_mr = 1;
    t_alu = 32'hDEAD_BEEF; t_rm = 32'h1234_5678; t_dest = 4'd7;
    repeat (4) begin
      cycle();
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++;
          $display("FAIL invalid d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
        end
      end
    end
    checks++;
    if ({a_vld[4], a_wb[4], a_mw[4], a_alu[4], a_dest[4], a_occ[4]} !== '0) begin
      errors++;
      $display("FAIL invalid_bubble_d4 got vld=%b wb=%b mw=%b alu=%h dest=%h occ=%0d exp all 0",
               a_vld[4], a_wb[4], a_mw[4], a_alu[4], a_dest[4], a_occ[4]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      t_in_valid = ($urandom_range(3) != 0);
      t_wb = 1'($urandom); t_mr = 1'($urandom); t_mw = 1'($urandom); t_s = 1'($urandom);
      t_status = 4'($urandom); t_dest = 4'($urandom);
      t_alu = $urandom; t_rm = $urandom;
      t_flush = ($urandom_range(7) == 0);
      t_freeze = ($urandom_range(5) == 0);
      cycle();
      for (int d = 1; d <= 4; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++;
          $display("FAIL b2b d=%0d cyc=%0d got=%h exp=%h", d, i, act_out(d), exp_out(d));
        end
      end
    end
    idle();
  endtask

  task automatic test_midreset();
    for (int i = 1; i <= 4; i++) begin
      idle();
      t_in_valid = 1; t_wb = 1; t_s = 1; t_status = 4'hF;
      t_alu = 32'h100 + 32'(i); t_dest = 4'(i + 8);
      cycle();
    end
    checks++;
    if (a_occ[4] !== 3'd4 || a_iwb[4] !== 4'hF || a_status[4] !== 4'hF) begin
      errors++;
      $display("FAIL midreset_fill got occ=%0d iwb=%b st=%h exp occ=4 iwb=1111 st=f", a_occ[4], a_iwb[4], a_status[4]);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (act_out(4) !== out_t'(0)) begin
      errors++;
      $display("FAIL midreset_d4 got=%h exp=0", act_out(4));
    end
    for (int d = 1; d <= 4; d++) begin
      checks++;
      if (act_out(d) !== exp_out(d)) begin
        errors++;
        $display("FAIL midreset d=%0d got=%h exp=%h", d, act_out(d), exp_out(d));
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single();
    test_stream();
    test_freeze_flush();
    test_status();
    test_invalid();
    test_back_to_back();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
